// File: rtl/sram_like_arbiter_if.sv
// One sram-like channel: an address phase (req/addr_ok) and an
// in-order response phase (data_ok/rdata). The master drives the
// request, and the slave answers it.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        cached;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata, cached,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata, cached,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-into-one sram-like bus arbiter. The inst fetch and data ports
// share one slave. A granted source stays locked until its address is
// accepted. Issued transactions are remembered in an in-order tag FIFO,
// so each response is routed back to the source that issued it. Data
// normally wins, but after DATA_STREAK_MAX data grants in a row with
// inst waiting, inst is forced through to prevent starvation.
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_STREAK_MAX = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_like_arbiter_if.slave   inst_sram,
    sram_like_arbiter_if.slave   data_sram,
    sram_like_arbiter_if.master  bus
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int STK_W = $clog2(DATA_STREAK_MAX + 1);

    localparam logic TAG_INST = 1'b0;
    localparam logic TAG_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_INST = 2'd1,
        HOLD_DATA = 2'd2
    } state_t;

    state_t               state;
    logic [STK_W-1:0]     streak;

    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic                 full;
    logic                 can_issue;
    logic                 streak_hit;
    logic                 sel_inst;
    logic                 sel_data;
    logic                 bus_req_int;
    logic                 handshake;
    logic                 pop;
    logic                 head_tag;

    // The full test looks at the registered count only. A pop in the same
    // cycle therefore cannot free a slot in time for an issue. Holding
    // reset also blocks issue, so nothing handshakes while reset is high.
    assign full       = (count == CNT_W'(MAX_OUTSTANDING));
    assign can_issue  = ~full & ~reset;
    assign streak_hit = (streak == STK_W'(DATA_STREAK_MAX));

    // Source selection: a held source stays locked. In IDLE, data wins
    // unless the streak limit has been reached.
    always_comb begin
        sel_inst = 1'b0;
        sel_data = 1'b0;
        if (!reset) begin
            case (state)
                HOLD_INST: sel_inst = 1'b1;
                HOLD_DATA: sel_data = 1'b1;
                default: begin
                    if (can_issue) begin
                        if (inst_sram.req && data_sram.req) begin
                            if (streak_hit) sel_inst = 1'b1;
                            else            sel_data = 1'b1;
                        end else if (inst_sram.req) begin
                            sel_inst = 1'b1;
                        end else if (data_sram.req) begin
                            sel_data = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus_req_int = ((sel_inst & inst_sram.req) | (sel_data & data_sram.req)) & can_issue;
    assign handshake   = bus_req_int & bus.addr_ok;
    assign pop         = bus.data_ok & (count != '0) & ~reset;
    assign head_tag    = tag_mem[rd_ptr];

    // Request fields are steered from the selected source. They are zero when nothing is selected.
    always_comb begin
        bus.req    = bus_req_int;
        bus.wr     = 1'b0;
        bus.size   = 2'b0;
        bus.wstrb  = 4'b0;
        bus.addr   = 32'b0;
        bus.wdata  = 32'b0;
        bus.cached = 1'b0;
        if (sel_inst) begin
            bus.wr     = inst_sram.wr;
            bus.size   = inst_sram.size;
            bus.wstrb  = inst_sram.wstrb;
            bus.addr   = inst_sram.addr;
            bus.wdata  = inst_sram.wdata;
            bus.cached = inst_sram.cached;
        end else if (sel_data) begin
            bus.wr     = data_sram.wr;
            bus.size   = data_sram.size;
            bus.wstrb  = data_sram.wstrb;
            bus.addr   = data_sram.addr;
            bus.wdata  = data_sram.wdata;
            bus.cached = data_sram.cached;
        end
    end

    // Handshake and response strobes go back to the owning source in the same cycle.
    assign inst_sram.addr_ok = handshake & sel_inst;
    assign data_sram.addr_ok = handshake & sel_data;
    assign inst_sram.data_ok = pop & (head_tag == TAG_INST);
    assign data_sram.data_ok = pop & (head_tag == TAG_DATA);
    assign inst_sram.rdata   = bus.rdata;
    assign data_sram.rdata   = bus.rdata;

    // Grant FSM and inst-starvation streak counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            if (handshake || !bus_req_int) begin
                state <= IDLE;
            end else begin
                state <= sel_inst ? HOLD_INST : HOLD_DATA;
            end

            if (!inst_sram.req) begin
                streak <= '0;
            end else if (handshake && sel_inst) begin
                streak <= '0;
            end else if (handshake && sel_data && !streak_hit) begin
                streak <= streak + 1'b1;
            end
        end
    end

    // In-order tag FIFO: push on address handshake, pop on response.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (handshake) begin
                tag_mem[wr_ptr] <= sel_data ? TAG_DATA : TAG_INST;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({handshake, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
